// File: rtl/serial_word_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_feeder
//  Description : Accepts parallel words over valid/ready and shifts them out
//                LSB-first on a single serial line, with an optional idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_feeder #(
    parameter int   WIDTH      = 14,
    parameter int   GAP        = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic [15:0]      word_cnt
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);
    localparam logic [7:0]         c_GAP_LAST = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [7:0]         r_gap_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic               r_ser_out;
    logic               r_ser_valid;
    logic               r_word_done;
    logic [15:0]        r_word_cnt;

    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_bit_cnt_nxt;
    logic [7:0]         w_gap_cnt_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic               w_ser_out_nxt;
    logic               w_ser_valid_nxt;
    logic               w_word_done_nxt;
    logic [15:0]        w_word_cnt_nxt;
    logic               w_last_bit;
    logic               w_gap_last;
    logic               w_ready;
    logic               w_accept;

    assign w_last_bit = (r_state == c_ST_SHIFT) && (r_bit_cnt == c_LAST_BIT);
    assign w_gap_last = (r_state == c_ST_GAP) && (r_gap_cnt == c_GAP_LAST);
    assign w_ready    = !rst && ((r_state == c_ST_IDLE) ||
                                 (w_last_bit && (GAP == 0)) ||
                                 w_gap_last);
    assign w_accept   = data_valid && w_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_shift_nxt     = r_shift;
        w_ser_out_nxt   = IDLE_LEVEL;
        w_ser_valid_nxt = 1'b0;
        w_word_done_nxt = 1'b0;
        w_word_cnt_nxt  = r_word_cnt;

        case (r_state)
            c_ST_IDLE: begin
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_SHIFT: begin
                if (!w_last_bit) begin
                    w_bit_cnt_nxt   = r_bit_cnt + 1'b1;
                    w_shift_nxt     = {1'b0, r_shift[WIDTH-1:1]};
                    w_ser_out_nxt   = r_shift[0];
                    w_ser_valid_nxt = 1'b1;
                    w_word_done_nxt = (w_bit_cnt_nxt == c_LAST_BIT);
                end else begin
                    if (r_word_cnt != 16'hFFFF) begin
                        w_word_cnt_nxt = r_word_cnt + 16'd1;
                    end
                    if (GAP > 0) begin
                        w_state_nxt   = c_ST_GAP;
                        w_gap_cnt_nxt = 8'd0;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            c_ST_GAP: begin
                if (w_gap_last) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // An accepted word overrides whatever the current state would do next,
        // which is what makes back-to-back streaming gapless.
        if (w_accept) begin
            w_state_nxt     = c_ST_SHIFT;
            w_bit_cnt_nxt   = '0;
            w_shift_nxt     = {1'b0, data_in[WIDTH-1:1]};
            w_ser_out_nxt   = data_in[0];
            w_ser_valid_nxt = 1'b1;
            w_word_done_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= 8'd0;
            r_shift     <= '0;
            r_ser_out   <= IDLE_LEVEL;
            r_ser_valid <= 1'b0;
            r_word_done <= 1'b0;
            r_word_cnt  <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_ser_out   <= w_ser_out_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_word_done <= w_word_done_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
        end
    end

    assign data_ready = w_ready;
    assign ser_out    = r_ser_out;
    assign ser_valid  = r_ser_valid;
    assign word_done  = r_word_done;
    assign word_cnt   = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_word_feeder
//  Description : Scoreboard bench for serial_word_feeder (GAP=0 and GAP=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_feeder;

    localparam int W = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  d0_data, d1_data;
    logic          d0_valid, d1_valid;
    logic          d0_ready, d0_ser, d0_sv, d0_done;
    logic          d1_ready, d1_ser, d1_sv, d1_done;
    logic [15:0]   d0_cnt, d1_cnt;

    int            n_checks = 0;
    int            n_fail   = 0;
    bit            exp_q[$];
    bit            exp_b;

    always #5 clk = ~clk;

    serial_word_feeder #(.WIDTH(W), .GAP(0), .IDLE_LEVEL(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(d0_data), .data_valid(d0_valid),
        .data_ready(d0_ready), .ser_out(d0_ser), .ser_valid(d0_sv),
        .word_done(d0_done), .word_cnt(d0_cnt)
    );

    serial_word_feeder #(.WIDTH(W), .GAP(3), .IDLE_LEVEL(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(d1_data), .data_valid(d1_valid),
        .data_ready(d1_ready), .ser_out(d1_ser), .ser_valid(d1_sv),
        .word_done(d1_done), .word_cnt(d1_cnt)
    );

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) exp_q.push_back(w[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1; d0_valid = 1'b0; d1_valid = 1'b0; d0_data = '0; d1_data = '0;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({d0_ser, d0_sv, d0_done, d0_ready, d0_cnt} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_dut0: got ser=%b sv=%b done=%b rdy=%b cnt=%h expected all 0",
                     d0_ser, d0_sv, d0_done, d0_ready, d0_cnt);
        end
        n_checks++;
        if ({d1_ser, d1_sv, d1_done, d1_ready, d1_cnt} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_dut1: got ser=%b sv=%b done=%b rdy=%b cnt=%h expected all 0",
                     d1_ser, d1_sv, d1_done, d1_ready, d1_cnt);
        end
    endtask

    // Word 7 accepted on the first edge with rst low; bits must appear 1 cycle later.
    task automatic test_single_word();
        rst = 1'b0; d0_data = 14'd7; d0_valid = 1'b1;
        #1;
        n_checks++;
        if (d0_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_ready: got %b expected 1", d0_ready);
        end
        if (d0_valid && d0_ready) push_word(d0_data);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (d0_sv !== (c <= 14)) begin
                n_fail++; $display("FAIL single_valid c=%0d: got %b expected %b", c, d0_sv, (c <= 14));
            end
            if (d0_sv) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL single_extra_bit c=%0d: got a bit expected none", c);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (d0_ser !== exp_b || d0_done !== (exp_q.size() == 0)) begin
                        n_fail++;
                        $display("FAIL single_bit c=%0d: got ser=%b done=%b expected ser=%b done=%b",
                                 c, d0_ser, d0_done, exp_b, (exp_q.size() == 0));
                    end
                end
            end else begin
                n_checks++;
                if (d0_ser !== 1'b0 || d0_done !== 1'b0) begin
                    n_fail++; $display("FAIL single_idle c=%0d: got ser=%b done=%b expected 0 0", c, d0_ser, d0_done);
                end
            end
            if (c == 1) d0_valid = 1'b0;
        end
        n_checks++;
        if (d0_cnt !== 16'd1 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL single_count: got cnt=%0d left=%0d expected cnt=1 left=0", d0_cnt, exp_q.size());
        end
    endtask

    // 72 words 0,7,...,497 with valid held high: one unbroken run of 1008 bits.
    task automatic test_back_to_back();
        int sent = 0, nbits = 0, dones = 0, first_c = -1, last_c = -1;
        bit acc = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; d0_data = '0; d0_valid = 1'b1;
        #1;
        if (d0_valid && d0_ready) begin push_word(d0_data); sent++; acc = 1'b1; end
        for (int c = 1; c <= 1100 && !(sent == 72 && exp_q.size() == 0); c++) begin
            @(negedge clk);
            if (d0_sv) begin
                nbits++; if (first_c < 0) first_c = c; last_c = c;
                if (d0_done) dones++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra_bit c=%0d: got a bit expected none", c);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (d0_ser !== exp_b) begin
                        n_fail++; $display("FAIL stream_bit c=%0d: got %b expected %b", c, d0_ser, exp_b);
                    end
                end
            end
            if (acc) begin
                acc = 1'b0;
                if (sent < 72) d0_data = W'(sent * 7);
                else d0_valid = 1'b0;
            end
            #1;
            if (d0_valid && d0_ready) begin push_word(d0_data); sent++; acc = 1'b1; end
        end
        @(negedge clk);
        n_checks++;
        if (nbits != 1008 || (last_c - first_c + 1) != 1008 || dones != 72) begin
            n_fail++;
            $display("FAIL stream_gapless: got bits=%0d span=%0d dones=%0d expected 1008 1008 72",
                     nbits, last_c - first_c + 1, dones);
        end
        n_checks++;
        if (d0_cnt !== 16'd72 || d0_sv !== 1'b0 || d0_ser !== 1'b0) begin
            n_fail++; $display("FAIL stream_end: got cnt=%0d sv=%b ser=%b expected 72 0 0", d0_cnt, d0_sv, d0_ser);
        end
    endtask

    // GAP=3: 3FFF then 0001; the second word is offered during the gap.
    task automatic test_gap();
        logic [3:0] obs, exp;
        d1_data = 14'h3FFF; d1_valid = 1'b1;
        #1;
        n_checks++;
        if (d1_ready !== 1'b1) begin
            n_fail++; $display("FAIL gap_idle_ready: got %b expected 1", d1_ready);
        end
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            obs = {d1_sv, d1_ser, d1_ready, d1_done};
            exp = {((c <= 14) || (c >= 18 && c <= 31)), ((c <= 14) || (c == 18)),
                   ((c == 17) || (c >= 34)), ((c == 14) || (c == 31))};
            n_checks++;
            if (obs !== exp) begin
                n_fail++; $display("FAIL gap_cycle c=%0d: got sv/ser/rdy/done=%b expected %b", c, obs, exp);
            end
            if (c == 1)  d1_data  = 14'h0001;
            if (c == 18) d1_valid = 1'b0;
        end
        n_checks++;
        if (d1_cnt !== 16'd2) begin
            n_fail++; $display("FAIL gap_count: got %0d expected 2", d1_cnt);
        end
    endtask

    // Reset during bit 6 of 2AAA, then 1555 accepted on the first edge after reset.
    task automatic test_reset_mid_word();
        d0_data = 14'h2AAA; d0_valid = 1'b1;
        #1;
        if (d0_valid && d0_ready) push_word(d0_data);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            n_checks++;
            exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
            if (d0_sv !== 1'b1 || d0_ser !== exp_b || d0_done !== 1'b0 || d0_cnt !== 16'd72) begin
                n_fail++;
                $display("FAIL abort_bit c=%0d: got sv=%b ser=%b done=%b cnt=%0d expected 1 %b 0 72",
                         c, d0_sv, d0_ser, d0_done, d0_cnt, exp_b);
            end
            if (c == 1) d0_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        n_checks++;
        if ({d0_sv, d0_ser, d0_done, d0_ready, d0_cnt} !== 20'h0) begin
            n_fail++;
            $display("FAIL abort_reset: got sv=%b ser=%b done=%b rdy=%b cnt=%0d expected all 0",
                     d0_sv, d0_ser, d0_done, d0_ready, d0_cnt);
        end
        rst = 1'b0; d0_data = 14'h1555; d0_valid = 1'b1;
        #1;
        n_checks++;
        if (d0_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_ready: got %b expected 1", d0_ready);
        end
        if (d0_valid && d0_ready) push_word(d0_data);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            n_checks++;
            if (d0_sv !== (c <= 14)) begin
                n_fail++; $display("FAIL after_abort_valid c=%0d: got %b expected %b", c, d0_sv, (c <= 14));
            end else if (d0_sv) begin
                exp_b = exp_q.pop_front();
                if (d0_ser !== exp_b || d0_done !== (c == 14)) begin
                    n_fail++;
                    $display("FAIL after_abort_bit c=%0d: got ser=%b done=%b expected ser=%b done=%b",
                             c, d0_ser, d0_done, exp_b, (c == 14));
                end
            end
            if (c == 1) d0_valid = 1'b0;
        end
        n_checks++;
        if (d0_cnt !== 16'd1) begin
            n_fail++; $display("FAIL after_abort_count: got %0d expected 1", d0_cnt);
        end
    endtask

    // data_in is scrambled every cycle while 1234 is being shifted.
    task automatic test_data_change();
        d0_data = 14'h1234; d0_valid = 1'b1;
        #1;
        if (d0_valid && d0_ready) push_word(d0_data);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            n_checks++;
            if (d0_sv !== (c <= 14)) begin
                n_fail++; $display("FAIL hold_valid c=%0d: got %b expected %b", c, d0_sv, (c <= 14));
            end else if (d0_sv) begin
                exp_b = exp_q.pop_front();
                if (d0_ser !== exp_b) begin
                    n_fail++; $display("FAIL hold_bit c=%0d: got %b expected %b", c, d0_ser, exp_b);
                end
            end
            d0_valid = 1'b0;
            d0_data  = W'($urandom);
        end
        n_checks++;
        if (d0_cnt !== 16'd2) begin
            n_fail++; $display("FAIL hold_count: got %0d expected 2", d0_cnt);
        end
    endtask

    // Counter preloaded to FFFE, then two words: must stop at FFFF.
    task automatic test_saturation();
        force u_dut0.r_word_cnt = 16'hFFFE;
        @(negedge clk);
        @(negedge clk);
        release u_dut0.r_word_cnt;
        n_checks++;
        if (d0_cnt !== 16'hFFFE) begin
            n_fail++; $display("FAIL sat_preload: got %h expected fffe", d0_cnt);
        end
        for (int w = 0; w < 2; w++) begin
            d0_data = W'(14'h0A5 + w); d0_valid = 1'b1;
            @(negedge clk);
            d0_valid = 1'b0;
            repeat (15) @(negedge clk);
            n_checks++;
            if (d0_cnt !== 16'hFFFF || d0_sv !== 1'b0) begin
                n_fail++; $display("FAIL sat_word%0d: got cnt=%h sv=%b expected ffff 0", w, d0_cnt, d0_sv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_gap();
        test_reset_mid_word();
        test_data_change();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
